cordic_descaler: RTL and testbench
==================================

Name: cordic_descaler

Overview:
- Sequential gain-application unit, the inverse direction of the combinational gain-compensation Scaler.
- Multiplies a 32-bit signed fixed-point operand by the CORDIC gain A of the selected mode: circular ≈1.646760, hyperbolic ≈0.828159, linear 1.0.
- Used to pre-distort operands before rotation, and to model or undo scaler output for verification.
- One-bit-per-cycle shift-add engine with valid/ready handshakes on input and output.

Parameters:
- DATA_W, 32, operand/result width, signed two's complement.
- FRAC, 16, fractional bits of operand, result and gain constants.
- GAIN_W, 18, gain constant width, unsigned (2 integer bits + FRAC fractional bits).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operand/mode present.
- in_ready  out  1  block can accept an operand.
- number  in  DATA_W  signed operand.
- mode  in  2  `CIRCULAR / `LINEAR / `HYPERBOLIC.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- answer  out  DATA_W  signed result.
- sat  out  1  result was saturated.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset).
- Reset values:
  - State = IDLE; in_ready=1; out_valid=0; answer=0; sat=0.
  - Accumulator and bit counter are cleared.
- Gain constant, selected from the mode captured at accept:
  - `CIRCULAR = 107922 (0x1A592).
  - `HYPERBOLIC = 54274 (0x0D402).
  - `LINEAR = 65536 (0x10000).
  - Undefined mode code (2'b11 slot) = 65536, i.e. pass-through. Not an error.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture number and gain, clear the 50-bit signed accumulator, set bit index = GAIN_W-1, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle: acc <= (acc<<<1) + (gain[idx] ? sign-extended number : 0); idx decrements.
  - After GAIN_W cycles (idx was 0), go to DONE.
- Entering DONE:
  - answer = acc>>>FRAC (arithmetic shift, floor rounding toward -inf).
  - If the shifted value is outside the signed DATA_W range, answer saturates to 0x7FFFFFFF or 0x80000000 (sign of acc) and sat=1; otherwise sat=0.
  - out_valid=1.
- DONE:
  - answer, sat and out_valid are held stable until out_ready=1.
  - On the out_valid&&out_ready cycle: return to IDLE and drop out_valid next cycle.
  - No bypass path: in_ready stays 0 while in DONE, so a new operand cannot be accepted in the same cycle.
- Latency:
  - Accept at cycle 0; out_valid first high at cycle GAIN_W+1 (19).
  - Minimum issue interval is GAIN_W+2 cycles with out_ready held high.
- Input changes on number/mode after accept have no effect.
- in_valid while not in IDLE is ignored; the source must hold it.
- reset asserted in RUN or DONE:
  - Aborts the operation; next cycle is IDLE with reset values.
  - The pending result is discarded; no out_valid pulse.
- out_ready low indefinitely: the block stalls in DONE with no loss.

Decomposition:
- Shared constants file (existing `CIRCULAR/`LINEAR/`HYPERBOLIC defines) additionally holds:
  - `GAIN_CIRC=18'h1A592
  - `GAIN_HYP=18'h0D402
  - `GAIN_LIN=18'h10000
  - state encodings for IDLE, RUN, DONE.
- One natural sub-module, descaler_gain_rom: combinational mode→gain lookup. It is reused by the verification model.
- FSM, accumulator and saturation logic stay in cordic_descaler.

Test Plan:
- Reset, then number=0x00140000 (20.0), mode=`CIRCULAR, out_ready=1 → out_valid at cycle 19, answer=0x0020EF68, sat=0.
- number=0x000A0000 (10.0), mode=`HYPERBOLIC → answer=0x00084814, sat=0. Same input with mode=2'b11 → 0x000A0000.
- number=0x00190000 (25.0), mode=`LINEAR → answer=0x00190000. number=0xFFFF0000 (-1.0), `CIRCULAR → 0xFFFE5A6E.
- number=0x7FFFFFFF, `CIRCULAR → answer=0x7FFFFFFF, sat=1. number=0x80000000, `CIRCULAR → 0x80000000, sat=1.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid → answer stable, in_ready=0 throughout.
  - Second in_valid presented during RUN is ignored and accepted only after the handshake.
- Assert reset at cycle 8 of RUN → next cycle in_ready=1, out_valid=0. The subsequent operation 20.0/`CIRCULAR is still correct (0x0020EF68).

Source files
------------

// File: rtl/cordic_descaler_pkg.sv
// Shared constants for the CORDIC gain descaler.
// Mode codes, gain constants and FSM state encodings.
package cordic_descaler_pkg;

  localparam logic [1:0] MODE_CIRC = 2'b00;
  localparam logic [1:0] MODE_LIN  = 2'b01;
  localparam logic [1:0] MODE_HYP  = 2'b10;

  localparam logic [17:0] GAIN_CIRC = 18'h1A592;
  localparam logic [17:0] GAIN_HYP  = 18'h0D402;
  localparam logic [17:0] GAIN_LIN  = 18'h10000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/descaler_gain_rom.sv
// Mode to CORDIC gain lookup.
// Unknown mode codes fall back to unity gain.
module descaler_gain_rom
  import cordic_descaler_pkg::*;
#(
  parameter int GAIN_W = 18
) (
  input  logic [1:0]        mode,
  output logic [GAIN_W-1:0] gain
);

  // decode mode into its gain constant
  always_comb begin
    gain = GAIN_W'(GAIN_LIN);
    unique case (1'b1)
      (mode == MODE_CIRC): gain = GAIN_W'(GAIN_CIRC);
      (mode == MODE_HYP):  gain = GAIN_W'(GAIN_HYP);
      default:             gain = GAIN_W'(GAIN_LIN);
    endcase
  end

endmodule

// File: rtl/cordic_descaler.sv
// Multiplies an operand by the CORDIC gain of a mode,
// one gain bit per cycle, MSB first, with saturation.
module cordic_descaler
  import cordic_descaler_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FRAC   = 16,
  parameter int GAIN_W = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] number,
  input  logic [1:0]        mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] answer,
  output logic              sat
);

  localparam int ACC_W = DATA_W + GAIN_W;
  localparam int SHF_W = ACC_W - FRAC;
  localparam int IDX_W = $clog2(GAIN_W);

  state_t                   state;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic signed [ACC_W-1:0]  addend;
  logic        [DATA_W-1:0] num_q;
  logic        [GAIN_W-1:0] gain_q;
  logic        [GAIN_W-1:0] gain_sel;
  logic        [IDX_W-1:0]  idx;
  logic        [SHF_W-1:0]  shf;
  logic        [SHF_W-DATA_W:0] hi;
  logic                     ovf;
  logic        [DATA_W-1:0] sat_val;

  descaler_gain_rom #(
    .GAIN_W(GAIN_W)
  ) u_rom (
    .mode(mode),
    .gain(gain_sel)
  );

  // next accumulator step and range check of its integer part
  always_comb begin
    addend = '0;
    if (gain_q[idx])
      addend = {{GAIN_W{num_q[DATA_W-1]}}, num_q};
    acc_nxt = (acc <<< 1) + addend;
    shf     = acc_nxt[ACC_W-1:FRAC];
    hi      = shf[SHF_W-1:DATA_W-1];
    ovf     = !((&hi) || !(|hi));
    sat_val = acc_nxt[ACC_W-1]
            ? {1'b1, {(DATA_W-1){1'b0}}}
            : {1'b0, {(DATA_W-1){1'b1}}};
  end

  // handshake FSM with the shift-add datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      answer    <= '0;
      sat       <= 1'b0;
      acc       <= '0;
      idx       <= '0;
      num_q     <= '0;
      gain_q    <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            num_q    <= number;
            gain_q   <= gain_sel;
            acc      <= '0;
            idx      <= IDX_W'(GAIN_W - 1);
            in_ready <= 1'b0;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc <= acc_nxt;
          idx <= idx - 1'b1;
          if (idx == '0) begin
            answer    <= ovf ? sat_val : shf[DATA_W-1:0];
            sat       <= ovf;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_descaler.sv
// Randomized bench for cordic_descaler against an
// arithmetic gain model with saturation.
module tb_cordic_descaler;
  import cordic_descaler_pkg::*;

  typedef struct {
    logic [31:0] ans;
    logic        s;
    time         t;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] number;
  logic [1:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] answer;
  logic        sat;

  int   n_chk  = 0;
  int   n_pass = 0;
  bit   rand_bp = 0;
  exp_t expq[$];
  logic [31:0] last_ans;
  logic        last_sat;

  cordic_descaler dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .number(number),
    .mode(mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .answer(answer),
    .sat(sat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [32:0] model(
    input logic [31:0] n,
    input logic [1:0]  m
  );
    longint g;
    longint p;
    longint q;
    if (m == MODE_CIRC)     g = 107922;
    else if (m == MODE_HYP) g = 54274;
    else                    g = 65536;
    p = longint'($signed(n)) * g;
    q = p >>> 16;
    if (q > 64'sd2147483647)
      return {1'b1, 32'h7FFFFFFF};
    if (q < -64'sd2147483648)
      return {1'b1, 32'h80000000};
    return {1'b0, q[31:0]};
  endfunction

  task automatic check(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic run_op(
    input logic [31:0] n,
    input logic [1:0]  m
  );
    int w;
    logic [32:0] e;
    w        = 0;
    number   = n;
    mode     = m;
    in_valid = 1'b1;
    while (!in_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      check("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e = model(n, m);
    expq.push_back('{ans: e[31:0], s: e[32], t: $time});
    #1;
    in_valid = 1'b0;
    number   = $urandom;
    mode     = 2'($urandom_range(0, 3));
    @(negedge clk);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (expq.size() != 0 && w < 800) begin
      @(negedge clk);
      w++;
    end
    check("drain_timeout", 64'(expq.size()), 64'd0);
    @(negedge clk);
  endtask

  initial begin : bp_gen
    forever begin
      @(posedge clk);
      #1;
      if (rand_bp)
        out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : cmp
    bit prev_ov;
    exp_t e;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        prev_ov = 1'b0;
        continue;
      end
      if (out_valid) begin
        if (expq.size() == 0) begin
          check("spurious_valid", 64'(out_valid), 64'd0);
        end else begin
          e = expq[0];
          check("answer", 64'(answer), 64'(e.ans));
          check("sat", 64'(sat), 64'(e.s));
          check("in_ready_done", 64'(in_ready), 64'd0);
          if (!prev_ov)
            check("latency", 64'($time - e.t), 64'd186);
          if (out_ready) begin
            last_ans = answer;
            last_sat = sat;
            void'(expq.pop_front());
          end
        end
      end
      prev_ov = out_valid && !out_ready;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int w;
    reset     = 1'b1;
    in_valid  = 1'b0;
    number    = '0;
    mode      = MODE_CIRC;
    out_ready = 1'b1;

    check("model_circ20", 64'(model(32'h00140000, MODE_CIRC)),
          64'({1'b0, 32'h0020EF68}));
    check("model_hyp10", 64'(model(32'h000A0000, MODE_HYP)),
          64'({1'b0, 32'h00084814}));
    check("model_undef", 64'(model(32'h000A0000, 2'b11)),
          64'({1'b0, 32'h000A0000}));
    check("model_neg1", 64'(model(32'hFFFF0000, MODE_CIRC)),
          64'({1'b0, 32'hFFFE5A6E}));
    check("model_satp", 64'(model(32'h7FFFFFFF, MODE_CIRC)),
          64'({1'b1, 32'h7FFFFFFF}));
    check("model_satn", 64'(model(32'h80000000, MODE_CIRC)),
          64'({1'b1, 32'h80000000}));

    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_answer", 64'(answer), 64'd0);
    check("rst_sat", 64'(sat), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(32'h00140000, MODE_CIRC);
    drain();
    check("dut_circ20", 64'(last_ans), 64'h0020EF68);
    check("dut_circ20_sat", 64'(last_sat), 64'd0);

    run_op(32'h000A0000, MODE_HYP);
    run_op(32'h000A0000, 2'b11);
    run_op(32'h00190000, MODE_LIN);
    run_op(32'hFFFF0000, MODE_CIRC);
    run_op(32'h7FFFFFFF, MODE_CIRC);
    drain();
    check("dut_satp_sat", 64'(last_sat), 64'd1);
    run_op(32'h80000000, MODE_CIRC);
    drain();
    check("dut_satn", 64'(last_ans), 64'h80000000);
    check("dut_satn_sat", 64'(last_sat), 64'd1);

    out_ready = 1'b0;
    run_op(32'h00030000, MODE_HYP);
    w = 0;
    while (!out_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("bp_valid_seen", 64'(out_valid), 64'd1);
    repeat (10) @(negedge clk);
    out_ready = 1'b1;
    drain();

    run_op(32'h00140000, MODE_CIRC);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    expq.delete();
    @(negedge clk);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    reset = 1'b0;
    repeat (25) @(negedge clk);
    run_op(32'h00140000, MODE_CIRC);
    drain();
    check("post_abort", 64'(last_ans), 64'h0020EF68);

    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] n;
      if ($urandom_range(0, 3) == 0)
        n = $urandom;
      else
        n = $urandom_range(0, 32'h01FFFFFF) - 32'h01000000;
      run_op(n, 2'($urandom_range(0, 3)));
    end
    drain();
    rand_bp   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
